// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared constants for the priority interrupt controller: register offsets
// inside the 8-byte window, the VEC register layout and the index width.
// No ports.
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

    // Register offsets (addr[2:0]) inside the window.
    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_VEC  = 3'd2;
    localparam logic [2:0] OFF_ISR  = 3'd3;
    localparam logic [2:0] OFF_EOI  = 3'd4;
    localparam logic [2:0] OFF_TRIG = 3'd5;

    // VEC read layout: {valid, 4'b0, idx[2:0]}.
    localparam int VEC_VALID_BIT = 7;
    localparam int IDX_W         = 3;

endpackage : irq_ctrl_pkg

// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if
// CPU-side bus of the interrupt controller (8-bit data, 16-bit address,
// rwb = 1 means read).
//   bus_en : bus cycle valid this clk          (master -> slave)
//   addr   : address                           (master -> slave)
//   rwb    : 1 = read, 0 = write               (master -> slave)
//   wdata  : write data                        (master -> slave)
//   rdata  : combinational read data, 0 when not selected (slave -> master)
//   sel    : address falls in the register window (slave -> master)
// -----------------------------------------------------------------------------
interface irq_ctrl_if;

    logic        bus_en;
    logic [15:0] addr;
    logic        rwb;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sel;

    modport master (
        output bus_en, addr, rwb, wdata,
        input  rdata, sel
    );

    modport slave (
        input  bus_en, addr, rwb, wdata,
        output rdata, sel
    );

endinterface : irq_ctrl_if

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational lowest-set-bit finder; bit 0 has the highest priority.
//   vec   : input vector, N bits
//   found : any bit of vec is set
//   idx   : index of the lowest set bit (0 when found = 0)
// -----------------------------------------------------------------------------
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output of a combinational block is given a default before
    // any conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan from the top down so the lowest set bit is the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule : irq_prio_enc

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Memory-mapped priority interrupt controller in front of the CPU irq input.
// Synchronises N_SRC rising-edge request lines, latches them in PEND, masks
// them with MASK, and raises irq when the best eligible source outranks the
// current in-service level (ISR), which allows nested interrupts.
//
// Register window (BASE_ADDR, 8 bytes, 8-aligned):
//   0 PEND  read pending, write-1-clears
//   1 MASK  read/write, 1 = enabled
//   2 VEC   read = acknowledge, {valid, 4'b0, idx}
//   3 ISR   read-only in-service
//   4 EOI   any write clears the lowest set ISR bit
//   5 TRIG  read/write level-trigger select (IRQ_CTRL_LEVEL_TRIG_EN only)
//   5-7     otherwise read 0, writes ignored
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   src  : asynchronous rising-edge request lines (bit 0 = highest priority)
//   bus  : CPU bus, slave side (see irq_ctrl_if)
//   irq  : registered interrupt request to the CPU
//
// Build option: define IRQ_CTRL_LEVEL_TRIG_EN to add the TRIG register; a
// source with TRIG set has PEND following its synchronised level.
// -----------------------------------------------------------------------------
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    irq_ctrl_if.slave        bus,
    output logic             irq
);

    logic [N_SRC-1:0] s1, s2, s3;
    logic [N_SRC-1:0] pend, mask, isr;
`ifdef IRQ_CTRL_LEVEL_TRIG_EN
    logic [N_SRC-1:0] trig;
`endif

    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_mask;
    logic [N_SRC-1:0] isr_ack;
    logic [N_SRC-1:0] eoi_clr;
    logic [N_SRC-1:0] pend_edge_next;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] isr_next;

    logic             elig_found, isr_found;
    logic [IDX_W-1:0] best, cur;
    logic             access, wr, rd, ack, eoi, irq_next;
    logic [2:0]       off;
    logic [7:0]       vec_word;

    // ---------------------------------------------------------------- decode
    assign bus.sel = (bus.addr[15:3] == BASE_ADDR[15:3]);
    assign access  = bus.bus_en & bus.sel;
    assign off     = bus.addr[2:0];
    assign wr      = access & ~bus.rwb;
    assign rd      = access & bus.rwb;

    // ------------------------------------------------------------- priority
    assign edge_det = s2 & ~s3;
    assign eligible = pend & mask;

    irq_prio_enc #(.N(N_SRC)) u_elig_enc (
        .vec   (eligible),
        .found (elig_found),
        .idx   (best)
    );

    irq_prio_enc #(.N(N_SRC)) u_isr_enc (
        .vec   (isr),
        .found (isr_found),
        .idx   (cur)
    );

    // A source may interrupt only when it outranks the current service level.
    assign irq_next = elig_found & (~isr_found | (best < cur));

    assign ack = rd & (off == OFF_VEC) & elig_found;
    assign eoi = wr & (off == OFF_EOI);
    assign w1c = (wr && off == OFF_PEND) ? bus.wdata[N_SRC-1:0] : '0;

    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_mask[i] = ack && (best == IDX_W'(i));
        end
    end

    // EOI sees the ISR with the same-cycle acknowledge already applied.
    assign isr_ack = isr | ack_mask;

    always_comb begin
        logic done;
        eoi_clr = '0;
        done    = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!done && isr_ack[i]) begin
                eoi_clr[i] = eoi;
                done       = 1'b1;
            end
        end
    end

    assign isr_next = isr_ack & ~eoi_clr;

    // A new edge wins over a clear arriving in the same cycle.
    assign pend_edge_next = (pend & ~w1c & ~ack_mask) | edge_det;

`ifdef IRQ_CTRL_LEVEL_TRIG_EN
    assign pend_next = (trig & s2) | (~trig & pend_edge_next);
`else
    assign pend_next = pend_edge_next;
`endif

    // ------------------------------------------------------------ read data
    always_comb begin
        vec_word                = '0;
        vec_word[VEC_VALID_BIT] = 1'b1;
        vec_word[IDX_W-1:0]     = best;
    end

    always_comb begin
        bus.rdata = 8'h00;
        if (bus.sel) begin
            case (off)
                OFF_PEND: bus.rdata = 8'(pend);
                OFF_MASK: bus.rdata = 8'(mask);
                OFF_VEC:  bus.rdata = elig_found ? vec_word : 8'h00;
                OFF_ISR:  bus.rdata = 8'(isr);
`ifdef IRQ_CTRL_LEVEL_TRIG_EN
                OFF_TRIG: bus.rdata = 8'(trig);
`endif
                default:  bus.rdata = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            s3   <= '0;
            pend <= '0;
            mask <= '0;
            isr  <= '0;
            irq  <= 1'b0;
        end else begin
            s1   <= src;
            s2   <= s1;
            s3   <= s2;
            pend <= pend_next;
            isr  <= isr_next;
            irq  <= irq_next;
            if (wr && off == OFF_MASK) begin
                mask <= bus.wdata[N_SRC-1:0];
            end
        end
    end

`ifdef IRQ_CTRL_LEVEL_TRIG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            trig <= '0;
        end else if (wr && off == OFF_TRIG) begin
            trig <= bus.wdata[N_SRC-1:0];
        end
    end
`endif

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Directed self-checking bench for irq_ctrl (default build, N_SRC = 8,
// BASE_ADDR = 16'hFF00). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam logic [15:0] BASE = 16'hFF00;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic       irq;
    logic [7:0] rd_val;

    int checks = 0;
    int errors = 0;

    irq_ctrl_if bus_if ();

    irq_ctrl #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .src (src),
        .bus (bus_if),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.bus_en = 1'b0;
        bus_if.addr   = 16'h0000;
        bus_if.rwb    = 1'b1;
        bus_if.wdata  = 8'h00;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_if.bus_en = 1'b1;
        bus_if.addr   = a;
        bus_if.rwb    = 1'b0;
        bus_if.wdata  = d;
        tick();
        bus_idle();
    endtask

    // rdata is sampled mid-cycle, i.e. from pre-edge state.
    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus_if.bus_en = 1'b1;
        bus_if.addr   = a;
        bus_if.rwb    = 1'b1;
        #1;
        d = bus_if.rdata;
        tick();
        bus_idle();
    endtask

    task automatic read_check(input string tag, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(BASE + 16'(off), d);
        check(tag, d, exp);
    endtask

    // One-cycle pulse; PEND holds the bit once this returns (3 edges).
    task automatic pulse(input int i);
        src[i] = 1'b1;
        tick();
        src[i] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        src = 8'h00;
        bus_idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset_irq", {7'd0, irq}, 8'h00);
        read_check("reset_pend", 3'd0, 8'h00);
        read_check("reset_mask", 3'd1, 8'h00);
        read_check("reset_isr",  3'd3, 8'h00);

        // Enable and fire
        bus_write(BASE + 16'd1, 8'h04);
        pulse(2);
        read_check("fire_pend", 3'd0, 8'h04);
        check("fire_irq_high", {7'd0, irq}, 8'h01);
        read_check("fire_vec", 3'd2, 8'h82);
        read_check("fire_isr", 3'd3, 8'h04);
        check("fire_irq_low", {7'd0, irq}, 8'h00);
        read_check("fire_pend_clr", 3'd0, 8'h00);
        bus_write(BASE + 16'd4, 8'h00);
        read_check("fire_eoi_isr", 3'd3, 8'h00);

        // Masked source stays pending
        bus_write(BASE + 16'd1, 8'h00);
        pulse(1);
        read_check("masked_pend", 3'd0, 8'h02);
        check("masked_irq", {7'd0, irq}, 8'h00);
        bus_write(BASE + 16'd1, 8'h02);
        check("unmask_irq_1edge", {7'd0, irq}, 8'h00);
        tick();
        check("unmask_irq_2edge", {7'd0, irq}, 8'h01);
        read_check("unmask_vec", 3'd2, 8'h81);
        bus_write(BASE + 16'd4, 8'h00);
        check("unmask_irq_done", {7'd0, irq}, 8'h00);
        read_check("unmask_isr", 3'd3, 8'h00);

        // Nesting
        bus_write(BASE + 16'd1, 8'h29);
        pulse(3);
        read_check("nest_vec3", 3'd2, 8'h83);
        pulse(5);
        tick();
        tick();
        check("nest_low_blocked", {7'd0, irq}, 8'h00);
        pulse(0);
        tick();
        check("nest_high_irq", {7'd0, irq}, 8'h01);
        read_check("nest_vec0", 3'd2, 8'h80);
        read_check("nest_isr09", 3'd3, 8'h09);
        bus_write(BASE + 16'd4, 8'h00);
        read_check("nest_isr08", 3'd3, 8'h08);
        check("nest_irq_still_blocked", {7'd0, irq}, 8'h00);
        bus_write(BASE + 16'd4, 8'h00);
        check("nest_irq_eoi_edge", {7'd0, irq}, 8'h00);
        tick();
        check("nest_irq_src5", {7'd0, irq}, 8'h01);
        read_check("nest_vec5", 3'd2, 8'h85);

        // Collisions (ISR = 8'h20 left in service)
        bus_write(BASE + 16'd1, 8'h00);
        pulse(0);
        read_check("coll_pend_first", 3'd0, 8'h01);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        tick();
        bus_write(BASE + 16'd0, 8'h01);
        read_check("coll_set_wins", 3'd0, 8'h01);
        bus_write(BASE + 16'd0, 8'h01);
        read_check("coll_w1c", 3'd0, 8'h00);
        read_check("coll_vec_empty", 3'd2, 8'h00);
        read_check("coll_isr_kept", 3'd3, 8'h20);
        bus_write(BASE + 16'd4, 8'h00);
        read_check("coll_isr_clr", 3'd3, 8'h00);

        // Reset mid-service, with an edge in the synchroniser
        bus_write(BASE + 16'd1, 8'h02);
        pulse(1);
        read_check("rst_vec", 3'd2, 8'h81);
        pulse(1);
        read_check("rst_pend_pre", 3'd0, 8'h02);
        src[2] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src[2] = 1'b0;
        check("rst_irq", {7'd0, irq}, 8'h00);
        read_check("rst_pend", 3'd0, 8'h00);
        read_check("rst_mask", 3'd1, 8'h00);
        read_check("rst_isr",  3'd3, 8'h00);
        tick();
        tick();
        read_check("rst_edge_lost", 3'd0, 8'h00);

        // Decode
        read_check("dec_off6", 3'd6, 8'h00);
        read_check("dec_off7", 3'd7, 8'h00);
        pulse(4);
        bus_if.bus_en = 1'b1;
        bus_if.addr   = BASE;
        bus_if.rwb    = 1'b1;
        #1;
        check("dec_sel_in", {7'd0, bus_if.sel}, 8'h01);
        bus_if.addr   = BASE + 16'd8;
        bus_if.rwb    = 1'b0;
        bus_if.wdata  = 8'h10;
        #1;
        check("dec_sel_out", {7'd0, bus_if.sel}, 8'h00);
        check("dec_rdata_out", bus_if.rdata, 8'h00);
        tick();
        bus_write(BASE + 16'd9, 8'hFF);
        bus_idle();
        read_check("dec_pend_kept", 3'd0, 8'h10);
        read_check("dec_mask_kept", 3'd1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_irq_ctrl
